reg_bus_master: RTL and testbench
=================================

Name: reg_bus_master

Overview:
- Upstream neighbour of the register-bus port decoder; sole master driving its registerSelect/registerRead/registerAddress/registerWriteData inputs.
- Converts a valid/ready request from the PCIe BAR target logic into one register-bus transaction.
- Waits for registerAck, with a timeout guard, and returns a valid/ready response carrying read data, error and timeout status.
- Keeps one transaction outstanding at a time, so acks returning through the decoder's pipeline can never be mismatched.

Parameters:
- TIMEOUT_CYCLES, 256: WAIT-state cycles allowed for registerAck before a timeout response; legal range 8 to 2^CNT_W-1.
- CNT_W, 16: width of the timeout counter and of each statistics counter.

Ports:
- clockCore  in  1  core clock; all logic on its rising edge.
- resetCore  in  1  synchronous, active-high reset.
- reqValid  in  1  request valid.
- reqReady  out  1  request accepted when reqValid && reqReady.
- reqRead  in  1  1 = read, 0 = write.
- reqAddress  in  32  register byte address.
- reqWriteData  in  32  write data; ignored for reads.
- rspValid  out  1  response valid.
- rspReady  in  1  response consumed when rspValid && rspReady.
- rspReadData  out  32  read data.
- rspError  out  1  slave error or timeout.
- rspTimeout  out  1  transaction timed out.
- registerSelect  out  1  single-cycle transaction strobe to the decoder.
- registerRead  out  1  read qualifier; valid with registerSelect.
- registerAddress  out  32  transaction address.
- registerWriteData  out  32  transaction write data.
- registerAck  in  1  single-cycle completion pulse from the decoder.
- registerError  in  1  slave error; meaningful only when registerAck = 1.
- registerReadData  in  32  read data; meaningful only when registerAck = 1.
- statTxnCount  out  CNT_W  completed transactions (optional feature).
- statTimeoutCount  out  CNT_W  timed-out transactions (optional feature).
- statLateAckCount  out  CNT_W  acks ignored outside WAIT (optional feature).

Behaviour:
- Clock and reset: one clock, clockCore; resetCore is synchronous and active-high.
- Reset values: every output is 0; state = IDLE. reqReady is registered, so it is 0 during reset and 1 in the first cycle after reset deasserts.
- Reset mid-transaction: the transaction is abandoned and no response is produced. A registerAck arriving after reset counts as a late ack.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - reqReady = 1.
  - On reqValid && reqReady, capture reqRead, reqAddress and reqWriteData into registerRead/registerAddress/registerWriteData, clear reqReady, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - registerSelect = 1; go to WAIT with the timeout counter = 0.
  - registerSelect is 0 in every other state.
  - registerAddress, registerWriteData and registerRead stay stable from ISSUE until the next request is captured.
- WAIT:
  - The counter increments every cycle.
  - registerAck = 1: go to RESP. Set rspReadData = registerRead ? registerReadData : 0, rspError = registerError, rspTimeout = 0.
  - No ack and counter == TIMEOUT_CYCLES-1: go to RESP with rspReadData = 32'hFFFF_FFFF, rspError = 1, rspTimeout = 1. This applies to writes too.
  - Ack in the same cycle as expiry: the ack wins.
  - Total WAIT length is at most TIMEOUT_CYCLES cycles.
- RESP:
  - rspValid = 1 from the first RESP cycle; rsp fields stay stable until rspReady.
  - On rspReady: rspValid = 0 and go to IDLE. reqReady rises in the same edge, so the next request can be accepted one cycle after the response handshake.
- registerAck outside WAIT (late ack after a timeout, or spurious ack) is ignored: no state change and no effect on rsp fields.
- Latency:
  - Accept edge to registerSelect: 1 cycle.
  - registerAck sample to rspValid: 1 cycle.
  - Timeout: rspValid asserts TIMEOUT_CYCLES+1 cycles after the registerSelect cycle.
- Throughput: one transaction in flight; reqReady = 0 in ISSUE, WAIT and RESP.

Optional Feature:
- Macro: REG_BUS_MASTER_STATS_EN.
- Defined:
  - statTxnCount increments on every RESP handshake, including timeouts.
  - statTimeoutCount increments on every timeout entry into RESP.
  - statLateAckCount increments on every registerAck sampled outside WAIT.
  - All three saturate at 2^CNT_W-1 and reset to 0.
- Undefined: the counter logic is not built; the three stat ports are tied to 0. The port list is identical either way.

Test Plan:
- Read at 0x0000_0040; slave acks 5 cycles after registerSelect with data 0x1234_5678, error 0 -> registerSelect high for exactly 1 cycle; rspValid one cycle after the ack; rspReadData 0x1234_5678, rspError 0, rspTimeout 0.
- Write at 0x0000_0100 with data 0xA5A5_A5A5; ack with registerError = 1 -> registerWriteData = 0xA5A5_A5A5 during ISSUE; rspReadData 0, rspError 1, rspTimeout 0.
- TIMEOUT_CYCLES = 16, no ack -> rspValid 17 cycles after registerSelect; rspReadData 0xFFFF_FFFF, rspError 1, rspTimeout 1. Repeat with the ack in the 16th WAIT cycle -> normal (non-timeout) response.
- Timeout, then ack 3 cycles later while rspReady is held 0 for 10 cycles -> rsp fields unchanged and reqReady 0 throughout. A following read returns its own data; with STATS, statLateAckCount = 1 and statTimeoutCount = 1.
- resetCore asserted for 1 cycle mid-WAIT -> all outputs 0 and no rspValid; reqReady = 1 the following cycle; the next read completes correctly.
- STATS build, 3 reads plus 1 timeout -> statTxnCount = 4, statTimeoutCount = 1. Non-STATS build -> all stat ports 0.

Source files
------------

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-outstanding register-bus master with ack timeout
// Optional statistics counters are built when REG_BUS_MASTER_STATS_EN is defined.
module reg_bus_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqRead,
  input  logic [31:0]      reqAddress,
  input  logic [31:0]      reqWriteData,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [31:0]      rspReadData,
  output logic             rspError,
  output logic             rspTimeout,
  output logic             registerSelect,
  output logic             registerRead,
  output logic [31:0]      registerAddress,
  output logic [31:0]      registerWriteData,
  input  logic             registerAck,
  input  logic             registerError,
  input  logic [31:0]      registerReadData,
  output logic [CNT_W-1:0] statTxnCount,
  output logic [CNT_W-1:0] statTimeoutCount,
  output logic [CNT_W-1:0] statLateAckCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_sel;
  logic             r_rd;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic             r_rsp_to;
  logic             w_expired;

  assign w_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_sel       <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_to    <= 1'b0;
    end else begin
      r_sel <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (reqValid && r_req_ready) begin
            r_rd        <= reqRead;
            r_addr      <= reqAddress;
            r_wdata     <= reqWriteData;
            r_req_ready <= 1'b0;
            r_sel       <= 1'b1;
            r_state     <= S_ISSUE;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // An ack in the expiry cycle still completes normally.
          if (registerAck) begin
            r_rsp_data  <= r_rd ? registerReadData : 32'h0;
            r_rsp_err   <= registerError;
            r_rsp_to    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_expired) begin
            r_rsp_data  <= 32'hFFFF_FFFF;
            r_rsp_err   <= 1'b1;
            r_rsp_to    <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rspReady) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign reqReady          = r_req_ready;
  assign rspValid          = r_rsp_valid;
  assign rspReadData       = r_rsp_data;
  assign rspError          = r_rsp_err;
  assign rspTimeout        = r_rsp_to;
  assign registerSelect    = r_sel;
  assign registerRead      = r_rd;
  assign registerAddress   = r_addr;
  assign registerWriteData = r_wdata;

`ifdef REG_BUS_MASTER_STATS_EN
  logic [CNT_W-1:0] r_txn_cnt;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] r_late_cnt;
  logic             w_txn_done;
  logic             w_to_entry;
  logic             w_late_ack;

  assign w_txn_done = (r_state == S_RESP) && rspReady;
  assign w_to_entry = (r_state == S_WAIT) && !registerAck && w_expired;
  assign w_late_ack = registerAck && (r_state != S_WAIT);

  // Counters saturate at all-ones.
  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      r_txn_cnt  <= '0;
      r_to_cnt   <= '0;
      r_late_cnt <= '0;
    end else begin
      if (w_txn_done && (r_txn_cnt != '1))  r_txn_cnt  <= r_txn_cnt + CNT_W'(1);
      if (w_to_entry && (r_to_cnt != '1))   r_to_cnt   <= r_to_cnt + CNT_W'(1);
      if (w_late_ack && (r_late_cnt != '1)) r_late_cnt <= r_late_cnt + CNT_W'(1);
    end
  end

  assign statTxnCount     = r_txn_cnt;
  assign statTimeoutCount = r_to_cnt;
  assign statLateAckCount = r_late_cnt;
`else
  assign statTxnCount     = '0;
  assign statTimeoutCount = '0;
  assign statLateAckCount = '0;
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed and randomized bench for reg_bus_master
module tb_reg_bus_master;
  localparam int T  = 16;
  localparam int CW = 16;

  logic          clockCore = 1'b0;
  logic          resetCore;
  logic          reqValid;
  logic          reqReady;
  logic          reqRead;
  logic [31:0]   reqAddress;
  logic [31:0]   reqWriteData;
  logic          rspValid;
  logic          rspReady;
  logic [31:0]   rspReadData;
  logic          rspError;
  logic          rspTimeout;
  logic          registerSelect;
  logic          registerRead;
  logic [31:0]   registerAddress;
  logic [31:0]   registerWriteData;
  logic          registerAck;
  logic          registerError;
  logic [31:0]   registerReadData;
  logic [CW-1:0] statTxnCount;
  logic [CW-1:0] statTimeoutCount;
  logic [CW-1:0] statLateAckCount;

  int vectors     = 0;
  int miscompares = 0;
  int m_txn       = 0;
  int m_to        = 0;
  int m_late      = 0;

  reg_bus_master #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clockCore(clockCore), .resetCore(resetCore),
    .reqValid(reqValid), .reqReady(reqReady), .reqRead(reqRead),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .rspValid(rspValid), .rspReady(rspReady), .rspReadData(rspReadData),
    .rspError(rspError), .rspTimeout(rspTimeout),
    .registerSelect(registerSelect), .registerRead(registerRead),
    .registerAddress(registerAddress), .registerWriteData(registerWriteData),
    .registerAck(registerAck), .registerError(registerError),
    .registerReadData(registerReadData),
    .statTxnCount(statTxnCount), .statTimeoutCount(statTimeoutCount),
    .statLateAckCount(statLateAckCount)
  );

  always #5 clockCore = ~clockCore;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef REG_BUS_MASTER_STATS_EN
    chk({tag, "_txn"}, 32'(statTxnCount), 32'(m_txn));
    chk({tag, "_to"}, 32'(statTimeoutCount), 32'(m_to));
    chk({tag, "_late"}, 32'(statLateAckCount), 32'(m_late));
`else
    chk({tag, "_txn"}, 32'(statTxnCount), 32'd0);
    chk({tag, "_to"}, 32'(statTimeoutCount), 32'd0);
    chk({tag, "_late"}, 32'(statLateAckCount), 32'd0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_reqReady"}, 32'(reqReady), 32'd0);
    chk({tag, "_rspValid"}, 32'(rspValid), 32'd0);
    chk({tag, "_rspData"}, rspReadData, 32'd0);
    chk({tag, "_rspErr"}, 32'(rspError), 32'd0);
    chk({tag, "_rspTo"}, 32'(rspTimeout), 32'd0);
    chk({tag, "_sel"}, 32'(registerSelect), 32'd0);
    chk({tag, "_rd"}, 32'(registerRead), 32'd0);
    chk({tag, "_addr"}, registerAddress, 32'd0);
    chk({tag, "_wdata"}, registerWriteData, 32'd0);
  endtask

  // Called at a negedge with the DUT idle. ack_at is the cycle (registerSelect
  // cycle = 0) in which the slave acks; outside 1..T means no ack (timeout).
  // late_at injects an extra ack while the response is pending.
  task automatic run_txn(input string tag, input logic rd, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] ack_data,
                         input logic ack_err, input int late_at, input int hold);
    logic        to;
    int          exp_k;
    logic [31:0] e_data;
    logic        e_err;
    to     = (ack_at < 1) || (ack_at > T);
    exp_k  = to ? T + 1 : ack_at + 1;
    e_data = to ? 32'hFFFF_FFFF : (rd ? ack_data : 32'h0);
    e_err  = to ? 1'b1 : ack_err;

    chk({tag, "_reqReady_idle"}, 32'(reqReady), 32'd1);
    reqValid = 1'b1; reqRead = rd; reqAddress = addr; reqWriteData = wd;
    @(negedge clockCore);
    reqValid = 1'b0; reqRead = ~rd; reqAddress = $urandom; reqWriteData = $urandom;
    chk({tag, "_sel_issue"}, 32'(registerSelect), 32'd1);
    chk({tag, "_addr_issue"}, registerAddress, addr);
    chk({tag, "_wdata_issue"}, registerWriteData, wd);
    chk({tag, "_rd_issue"}, 32'(registerRead), 32'(rd));
    chk({tag, "_reqReady_issue"}, 32'(reqReady), 32'd0);
    registerAck = 1'b0;

    for (int k = 1; k <= exp_k + hold; k++) begin
      @(negedge clockCore);
      chk({tag, "_sel"}, 32'(registerSelect), 32'd0);
      chk({tag, "_reqReady_busy"}, 32'(reqReady), 32'd0);
      chk({tag, "_rspValid"}, 32'(rspValid), 32'(k >= exp_k));
      chk({tag, "_addr_hold"}, registerAddress, addr);
      if (k >= exp_k) begin
        chk({tag, "_rspData"}, rspReadData, e_data);
        chk({tag, "_rspErr"}, 32'(rspError), 32'(e_err));
        chk({tag, "_rspTo"}, 32'(rspTimeout), 32'(to));
      end
      registerAck      = (k == ack_at) || (k == late_at);
      registerReadData = (k == ack_at) ? ack_data : $urandom;
      registerError    = (k == ack_at) ? ack_err : 1'($urandom);
      rspReady         = (k == exp_k + hold);
    end
    @(negedge clockCore);
    registerAck = 1'b0;
    rspReady    = 1'b0;
    chk({tag, "_rspValid_done"}, 32'(rspValid), 32'd0);
    chk({tag, "_reqReady_done"}, 32'(reqReady), 32'd1);
    m_txn++;
    if (to) m_to++;
    if (late_at > exp_k) m_late++;
    chk_stats(tag);
  endtask

  initial begin
    logic rd;
    int   dly;
    resetCore = 1'b1; reqValid = 1'b0; reqRead = 1'b0; reqAddress = '0; reqWriteData = '0;
    rspReady = 1'b0; registerAck = 1'b0; registerError = 1'b0; registerReadData = '0;
    repeat (3) @(negedge clockCore);
    chk_all_zero("reset");
    chk_stats("reset");
    resetCore = 1'b0;
    @(negedge clockCore);
    chk("reqReady_after_reset", 32'(reqReady), 32'd1);

    run_txn("rd_basic", 1'b1, 32'h0000_0040, 32'h0, 5, 32'h1234_5678, 1'b0, 0, 0);
    run_txn("wr_err", 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 3, 32'hDEAD_BEEF, 1'b1, 0, 2);
    run_txn("timeout", 1'b1, 32'h0000_0200, 32'h0, 0, 32'h0, 1'b0, 0, 0);
    run_txn("ack_last", 1'b1, 32'h0000_0204, 32'h0, T, 32'hCAFE_F00D, 1'b0, 0, 1);
    run_txn("to_late", 1'b0, 32'h0000_0300, 32'h1111_2222, 0, 32'h0, 1'b0, T + 4, 10);
    run_txn("after_late", 1'b1, 32'h0000_0304, 32'h0, 2, 32'h5555_AAAA, 1'b0, 0, 0);

    // Reset in the middle of WAIT abandons the transaction.
    reqValid = 1'b1; reqRead = 1'b1; reqAddress = 32'h0000_0400; reqWriteData = 32'h0;
    @(negedge clockCore);
    reqValid = 1'b0;
    repeat (3) @(negedge clockCore);
    resetCore = 1'b1;
    @(negedge clockCore);
    resetCore = 1'b0;
    m_txn = 0; m_to = 0; m_late = 0;
    chk_all_zero("midreset");
    registerAck = 1'b1; registerReadData = 32'h7777_7777;
    @(negedge clockCore);
    registerAck = 1'b0;
    m_late++;
    chk("midreset_reqReady", 32'(reqReady), 32'd1);
    chk("midreset_rspValid", 32'(rspValid), 32'd0);
    chk_stats("midreset");

    run_txn("post_rd1", 1'b1, 32'h0000_0404, 32'h0, 4, 32'h0BAD_CAFE, 1'b0, 0, 0);
    run_txn("post_rd2", 1'b1, 32'h0000_0408, 32'h0, 1, 32'h1357_9BDF, 1'b0, 0, 1);
    run_txn("post_to", 1'b0, 32'h0000_040C, 32'h2468_ACE0, 0, 32'h0, 1'b0, 0, 0);
    run_txn("post_rd3", 1'b1, 32'h0000_0410, 32'h0, 7, 32'hFEED_FACE, 1'b1, 0, 0);

    for (int i = 0; i < 12; i++) begin
      rd  = 1'($urandom);
      dly = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, T));
      run_txn("rand", rd, $urandom, $urandom, dly, $urandom, 1'($urandom), 0,
              int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
